// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on a valid/ready handshake and
// emits them one bit per clock, streaming consecutive words with no gap cycle.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    at_last    = (state == SHIFT) && (cnt == LAST);
    accept     = load_valid && ((state == IDLE) || at_last);
    if (accept) begin
      state_next = SHIFT;
      sr_next    = load_data;
      cnt_next   = '0;
    end else if (state == SHIFT) begin
      // Shift on the final bit too so the register drains to zero; cnt holds at LAST.
      sr_next = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      if (at_last) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    load_ready = 1'b1;
    sout       = IDLE_BIT;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (state == SHIFT) begin
      sout_valid = 1'b1;
      busy       = 1'b1;
      sout       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
      done       = (cnt == LAST);
      load_ready = (cnt == LAST);
    end
  end

endmodule
